border_row_sequencer: RTL and testbench

BORDER_ROW_SEQUENCER -- requirements
Module: border_row_sequencer

---
 rtl/border_row_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_border_row_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/border_row_sequencer.sv
// Row sequencer for a 3-row line-buffer filter: streams pixels into three
// rotating line buffers and issues per-row process commands with replicated borders.
module border_row_sequencer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic       wr_en,
  output logic [1:0] wr_buf,
  output logic [8:0] wr_addr,
  output logic [1:0] sel_top,
  output logic [1:0] sel_mid,
  output logic [1:0] sel_bot,
  output logic       proc_start,
  output logic [7:0] proc_row,
  input  logic       proc_done,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, PROC = 2'd2, DONE = 2'd3} state_t;

  localparam logic [8:0] X_LAST   = 9'(WIDTH - 1);
  localparam logic [8:0] ROWS_ALL = 9'(HEIGHT);
  localparam logic [7:0] ROW_LAST = 8'(HEIGHT - 1);

  state_t     state_r;
  logic [8:0] x_r;
  logic [8:0] rows_in_r;
  logic [7:0] out_row_r;
  logic [1:0] wbuf_r;
  logic [1:0] omod_r;
  logic       pix_ready_r;
  logic       proc_start_r;
  logic       busy_r;
  logic       frame_done_r;
  logic [1:0] sel_top_r;
  logic [1:0] sel_mid_r;
  logic [1:0] sel_bot_r;
  logic [7:0] proc_row_r;

  logic       accept_s;
  logic [7:0] next_row_s;
  logic [1:0] next_mod_s;

  function automatic logic [1:0] mod3_inc(input logic [1:0] m);
    case (m)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] mod3_dec(input logic [1:0] m);
    case (m)
      2'd1:    return 2'd0;
      2'd2:    return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  // Rows that must be resident before output row r can run (below-row clamped at the frame end).
  function automatic logic [8:0] rows_needed(input logic [7:0] r);
    logic [8:0] r2;
    r2 = {1'b0, r} + 9'd2;
    if (r2 > ROWS_ALL) return ROWS_ALL;
    else               return r2;
  endfunction

  // {top, mid, bot} buffer indices for row r whose buffer is m; edges reuse the mid buffer.
  function automatic logic [5:0] sel_for(input logic [7:0] r, input logic [1:0] m);
    logic [1:0] t;
    logic [1:0] b;
    t = (r == 8'd0)     ? m : mod3_dec(m);
    b = (r == ROW_LAST) ? m : mod3_inc(m);
    return {t, m, b};
  endfunction

  assign accept_s   = pix_valid & pix_ready_r;
  assign next_row_s = out_row_r + 8'd1;
  assign next_mod_s = mod3_inc(omod_r);

  assign pix_ready  = pix_ready_r;
  assign wr_en      = accept_s;
  assign wr_buf     = wbuf_r;
  assign wr_addr    = x_r;
  assign sel_top    = sel_top_r;
  assign sel_mid    = sel_mid_r;
  assign sel_bot    = sel_bot_r;
  assign proc_start = proc_start_r;
  assign proc_row   = proc_row_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

  // Frame sequencing FSM with all command outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      x_r          <= 9'd0;
      rows_in_r    <= 9'd0;
      out_row_r    <= 8'd0;
      wbuf_r       <= 2'd0;
      omod_r       <= 2'd0;
      pix_ready_r  <= 1'b0;
      proc_start_r <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      sel_top_r    <= 2'd0;
      sel_mid_r    <= 2'd0;
      sel_bot_r    <= 2'd0;
      proc_row_r   <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (frame_start) begin
            x_r         <= 9'd0;
            rows_in_r   <= 9'd0;
            out_row_r   <= 8'd0;
            wbuf_r      <= 2'd0;
            omod_r      <= 2'd0;
            pix_ready_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= FILL;
          end
        end
        FILL: begin
          if (accept_s) begin
            if (x_r == X_LAST) begin
              x_r       <= 9'd0;
              rows_in_r <= rows_in_r + 9'd1;
              wbuf_r    <= mod3_inc(wbuf_r);
              if ((rows_in_r + 9'd1) == rows_needed(out_row_r)) begin
                state_r      <= PROC;
                pix_ready_r  <= 1'b0;
                proc_start_r <= 1'b1;
                {sel_top_r, sel_mid_r, sel_bot_r} <= sel_for(out_row_r, omod_r);
                proc_row_r   <= out_row_r;
              end
            end else begin
              x_r <= x_r + 9'd1;
            end
          end
        end
        PROC: begin
          proc_start_r <= 1'b0;
          // A done coinciding with the start pulse belongs to the previous command and is dropped.
          if (proc_done && !proc_start_r) begin
            if (out_row_r == ROW_LAST) begin
              state_r      <= DONE;
              frame_done_r <= 1'b1;
              {sel_top_r, sel_mid_r, sel_bot_r} <= 6'd0;
              proc_row_r   <= 8'd0;
            end else begin
              out_row_r <= next_row_s;
              omod_r    <= next_mod_s;
              if (rows_in_r >= rows_needed(next_row_s)) begin
                proc_start_r <= 1'b1;
                {sel_top_r, sel_mid_r, sel_bot_r} <= sel_for(next_row_s, next_mod_s);
                proc_row_r   <= next_row_s;
              end else begin
                state_r     <= FILL;
                pix_ready_r <= 1'b1;
                {sel_top_r, sel_mid_r, sel_bot_r} <= 6'd0;
                proc_row_r  <= 8'd0;
              end
            end
          end
        end
        DONE: begin
          frame_done_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          state_r      <= IDLE;
          pix_ready_r  <= 1'b0;
          proc_start_r <= 1'b0;
          busy_r       <= 1'b0;
          frame_done_r <= 1'b0;
          {sel_top_r, sel_mid_r, sel_bot_r} <= 6'd0;
          proc_row_r   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_border_row_sequencer.sv
// Scoreboard bench for border_row_sequencer: a 4x3 instance under directed frames
// and a 20x10 instance for whole-frame event counts.
module tb_border_row_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, frame_start, pix_valid, proc_done;
  logic       pix_ready, wr_en, proc_start, busy, frame_done;
  logic [1:0] wr_buf, sel_top, sel_mid, sel_bot;
  logic [8:0] wr_addr;
  logic [7:0] proc_row;

  logic       rst_nb, fs_b, pv_b, pd_b;
  logic       pr_b, we_b, ps_b, busy_b, fd_b;
  logic [1:0] wb_b, st_b, sm_b, sb_b;
  logic [8:0] wa_b;
  logic [7:0] prow_b;

  typedef struct { int b; int a; } wr_t;
  typedef struct { int row; int top; int mid; int bot; } pr_t;
  wr_t wq[$];
  pr_t pq[$];
  wr_t mon_w;
  pr_t mon_p;

  int checks = 0;
  int errors = 0;
  bit toggle_en = 1'b0;
  int nw_b = 0, np_b = 0, nf_b = 0;

  border_row_sequencer #(.WIDTH(4), .HEIGHT(3)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .wr_en(wr_en), .wr_buf(wr_buf), .wr_addr(wr_addr),
    .sel_top(sel_top), .sel_mid(sel_mid), .sel_bot(sel_bot), .proc_start(proc_start),
    .proc_row(proc_row), .proc_done(proc_done), .busy(busy), .frame_done(frame_done)
  );

  border_row_sequencer #(.WIDTH(20), .HEIGHT(10)) dut_b (
    .clk(clk), .rst_n(rst_nb), .frame_start(fs_b), .pix_valid(pv_b),
    .pix_ready(pr_b), .wr_en(we_b), .wr_buf(wb_b), .wr_addr(wa_b),
    .sel_top(st_b), .sel_mid(sm_b), .sel_bot(sb_b), .proc_start(ps_b),
    .proc_row(prow_b), .proc_done(pd_b), .busy(busy_b), .frame_done(fd_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write and every process command must match the next expectation.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wq.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        mon_w = wq.pop_front();
        chk("wr_buf", int'(wr_buf), mon_w.b);
        chk("wr_addr", int'(wr_addr), mon_w.a);
      end
    end
    if (proc_start === 1'b1) begin
      if (pq.size() == 0) chk("unexpected_proc_start", 1, 0);
      else begin
        mon_p = pq.pop_front();
        chk("proc_row", int'(proc_row), mon_p.row);
        chk("sel_top", int'(sel_top), mon_p.top);
        chk("sel_mid", int'(sel_mid), mon_p.mid);
        chk("sel_bot", int'(sel_bot), mon_p.bot);
      end
    end
  end

  always @(negedge clk) begin
    if (we_b === 1'b1) nw_b++;
    if (ps_b === 1'b1) np_b++;
    if (fd_b === 1'b1) nf_b++;
  end

  always begin
    @(posedge clk); #1;
    if (toggle_en) pix_valid = ~pix_valid;
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_ready"}, int'(pix_ready), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_proc_start"}, int'(proc_start), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_sel"}, int'({sel_top, sel_mid, sel_bot}), 0);
    chk({tag, "_proc_row"}, int'(proc_row), 0);
  endtask

  task automatic wait_proc(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (proc_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One 4x3 frame: rows 0/1/2 expect sel (top,mid,bot) 0/0/1, 0/1/2, 1/2/2.
  task automatic run_frame(input bit toggle);
    bit ok;
    int exp_sel [3][3];
    exp_sel[0][0] = 0; exp_sel[0][1] = 0; exp_sel[0][2] = 1;
    exp_sel[1][0] = 0; exp_sel[1][1] = 1; exp_sel[1][2] = 2;
    exp_sel[2][0] = 1; exp_sel[2][1] = 2; exp_sel[2][2] = 2;
    for (int b = 0; b < 3; b++)
      for (int a = 0; a < 4; a++) wq.push_back('{b, a});
    for (int r = 0; r < 3; r++) pq.push_back('{r, exp_sel[r][0], exp_sel[r][1], exp_sel[r][2]});
    @(posedge clk); #1;
    frame_start = 1'b1;
    if (toggle) toggle_en = 1'b1;
    else pix_valid = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wait_proc(ok);
      if (!ok) begin
        chk("proc_start_timeout", 0, 1);
        toggle_en = 1'b0;
        return;
      end
      chk("pix_ready_at_start", int'(pix_ready), 0);
      proc_done = 1'b1;
      @(posedge clk); #1;
      proc_done = 1'b0;
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      @(negedge clk);
      chk("proc_hold_pix_ready", int'(pix_ready), 0);
      chk("proc_hold_busy", int'(busy), 1);
      chk("proc_hold_start", int'(proc_start), 0);
      chk("proc_hold_row", int'(proc_row), r);
      chk("proc_hold_sel", int'({sel_top, sel_mid, sel_bot}),
          exp_sel[r][0] * 16 + exp_sel[r][1] * 4 + exp_sel[r][2]);
      @(posedge clk); #1;
      proc_done = 1'b1;
      @(posedge clk); #1;
      proc_done = 1'b0;
      if (r == 2) begin
        @(negedge clk);
        chk("frame_done_pulse", int'(frame_done), 1);
        chk("sel_zero_in_done", int'({sel_top, sel_mid, sel_bot, proc_row}), 0);
        @(negedge clk);
        chk("frame_done_cleared", int'(frame_done), 0);
        chk("busy_after_frame", int'(busy), 0);
      end
    end
    toggle_en = 1'b0;
    pix_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    pix_valid = 1'b0;
    chk("write_queue_drained", wq.size(), 0);
    chk("proc_queue_drained", pq.size(), 0);
  endtask

  initial begin
    int cd;
    rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; proc_done = 1'b0;
    rst_nb = 1'b0; fs_b = 1'b0; pv_b = 1'b0; pd_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pix_valid = 1'b1;
    #1;
    chk_all_zero("reset");
    pix_valid = 1'b0;
    rst_n = 1'b1;
    rst_nb = 1'b1;

    // proc_done and pix_valid in IDLE do nothing
    @(posedge clk); #1;
    proc_done = 1'b1;
    pix_valid = 1'b1;
    @(posedge clk); #1;
    proc_done = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_pix_ready", int'(pix_ready), 0);
    pix_valid = 1'b0;

    run_frame(1'b0);
    run_frame(1'b1);

    // Reset after five accepted pixels
    for (int a = 0; a < 4; a++) wq.push_back('{0, a});
    wq.push_back('{1, 0});
    @(posedge clk); #1;
    frame_start = 1'b1;
    pix_valid = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (wq.size() == 0) break;
    end
    chk("midfill_writes_seen", wq.size(), 0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midfill_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("post_reset_pix_ready", int'(pix_ready), 0);
    chk("post_reset_busy", int'(busy), 0);
    pix_valid = 1'b0;

    run_frame(1'b0);

    // Whole-frame counts on the 20x10 instance
    @(posedge clk); #1;
    fs_b = 1'b1;
    pv_b = 1'b1;
    @(posedge clk); #1;
    fs_b = 1'b0;
    cd = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ps_b === 1'b1) cd = 3;
      pd_b = (cd == 1);
      if (cd > 0) cd--;
    end
    pd_b = 1'b0;
    chk("b_writes", nw_b, 200);
    chk("b_proc_starts", np_b, 10);
    chk("b_frame_done", nf_b, 1);
    chk("b_busy_end", int'(busy_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
